// File: rtl/block_check_pkg.sv
// Shared types and constants for the block-checker scheduler and its checker.
package block_check_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_SETTLE = 3'd4,
        S_REPORT = 3'd5
    } state_e;

    // Character codes the keyword checker keys on ('b'egin / en'd')
    localparam logic [7:0] CH_B = 8'h62;
    localparam logic [7:0] CH_D = 8'h64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after ptr, with wrap.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic             grant_valid_o,
    output logic [ID_W-1:0]  grant_id_o
);

    int idx;

    always_comb begin
        grant_valid_o = 1'b0;
        grant_id_o    = '0;
        idx           = 0;
        // Offset 1..N_REQ so the previous owner is searched last
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr_i) + k) % N_REQ;
            if (!grant_valid_o && req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_id_o    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/block_check_scheduler.sv
// Shares one begin/end block checker among N_REQ character sources, one whole
// string at a time, and reports each verdict on a done channel.
module block_check_scheduler
    import block_check_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int MAX_LEN = 1024,
    parameter int LEN_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               chk_clr,
    output logic               chk_en,
    output logic [7:0]         chk_in,
    input  logic               chk_result,
    output logic               done_valid,
    input  logic               done_ready,
    output logic [ID_W-1:0]    done_id,
    output logic               done_result,
    output logic [LEN_W-1:0]   done_len,
    output logic               done_ovf,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovf_q, ovf_d;
    logic               result_q, result_d;

    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic               owner_valid;
    logic               owner_last;
    logic [7:0]         owner_data;
    logic [LEN_W-1:0]   len_inc;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_i         (req_valid),
        .ptr_i         (ptr_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    assign owner_valid = req_valid[owner_q];
    assign owner_last  = req_last[owner_q];
    assign owner_data  = req_data[{owner_q, 3'b000} +: 8];
    // Saturating increment: the length never wraps past MAX_LEN
    assign len_inc     = (len_q == LEN_W'(MAX_LEN)) ? len_q : len_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            ptr_q    <= ID_W'(N_REQ - 1);
            len_q    <= '0;
            ovf_q    <= 1'b0;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        req_ready  = '0;
        chk_clr    = 1'b0;
        chk_en     = 1'b0;
        chk_in     = 8'h00;
        done_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_id;
                    ptr_d   = grant_id;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                chk_clr = 1'b1;
                len_d   = '0;
                ovf_d   = 1'b0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                req_ready[owner_q] = 1'b1;
                if (owner_valid) begin
                    chk_en = 1'b1;
                    chk_in = owner_data;
                    len_d  = len_inc;
                    if (owner_last) begin
                        state_d = S_SETTLE;
                    end else if (len_inc == LEN_W'(MAX_LEN)) begin
                        ovf_d   = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Swallow the rest of an oversized string without feeding the checker
                req_ready[owner_q] = 1'b1;
                if (owner_valid && owner_last) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                result_d = chk_result & ~ovf_q;
                state_d  = S_REPORT;
            end
            S_REPORT: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign done_id     = owner_q;
    assign done_result = result_q;
    assign done_len    = len_q;
    assign done_ovf    = ovf_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_block_check_scheduler.sv
// Directed bench for block_check_scheduler: table of single strings plus
// hand-written sequences for arbitration, back-pressure, stalls, overflow and reset.
module tb_block_check_scheduler;
    import block_check_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int LW  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           chk_clr, chk_en, chk_result;
    logic [7:0]     chk_in;
    logic           done_valid, done_ready, done_result, done_ovf, busy;
    logic [IDW-1:0] done_id;
    logic [LW-1:0]  done_len;

    logic [N-1:0]   b_req_valid, b_req_last, b_req_ready;
    logic [8*N-1:0] b_req_data;
    logic           b_chk_clr, b_chk_en, b_chk_result;
    logic [7:0]     b_chk_in;
    logic           b_done_valid, b_done_ready, b_done_result, b_done_ovf, b_busy;
    logic [IDW-1:0] b_done_id;
    logic [LW-1:0]  b_done_len;

    block_check_scheduler #(.N_REQ(N), .ID_W(IDW), .MAX_LEN(1024), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .chk_clr(chk_clr), .chk_en(chk_en),
        .chk_in(chk_in), .chk_result(chk_result), .done_valid(done_valid),
        .done_ready(done_ready), .done_id(done_id), .done_result(done_result),
        .done_len(done_len), .done_ovf(done_ovf), .busy(busy)
    );

    block_check_scheduler #(.N_REQ(N), .ID_W(IDW), .MAX_LEN(4), .LEN_W(LW)) dut_ovf (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_data(b_req_data),
        .req_last(b_req_last), .req_ready(b_req_ready), .chk_clr(b_chk_clr), .chk_en(b_chk_en),
        .chk_in(b_chk_in), .chk_result(b_chk_result), .done_valid(b_done_valid),
        .done_ready(b_done_ready), .done_id(b_done_id), .done_result(b_done_result),
        .done_len(b_done_len), .done_ovf(b_done_ovf), .busy(b_busy)
    );

    // Checker stand-in: verdict is 1 when the counts of 'b' and 'd' match
    logic [7:0] nb_q = 8'd0;
    logic [7:0] nd_q = 8'd0;
    always @(posedge clk) begin
        if (chk_clr) begin
            nb_q <= 8'd0;
            nd_q <= 8'd0;
        end else if (chk_en) begin
            if (chk_in == CH_B) nb_q <= nb_q + 8'd1;
            if (chk_in == CH_D) nd_q <= nd_q + 8'd1;
        end
    end
    assign chk_result = (nb_q == nd_q);

    typedef struct { int id; string s; bit res; } vec_t;
    typedef struct { int id; int len; bit res; bit ovf; int vcyc; } rec_t;

    int   checks = 0;
    int   errors = 0;
    byte  bufm [N][64];
    int   blen [N];
    int   pos [N];
    int   gap_at [N];
    int   gap_left [N];
    bit   in_gap;
    logic [N-1:0] acc;
    int   cyc = 0;
    int   clr_cnt, en_cnt, first_clr, first_en, last_acc, dv_rise, hs_cyc;
    int   gap_seen, gap_en, gap_len_bad, chkin_bad;
    bit   dv_prev;
    byte  en_chars [64];
    rec_t recs [$];
    vec_t vecs [5];

    function automatic vec_t mk(input int id, input string s, input bit r);
        vec_t v;
        v.id = id; v.s = s; v.res = r;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive();
        in_gap = 1'b0;
        for (int i = 0; i < N; i++) begin
            bit v;
            v = (pos[i] < blen[i]);
            if (v && pos[i] == gap_at[i] && gap_left[i] > 0) begin
                v = 1'b0;
                gap_left[i]--;
                in_gap = 1'b1;
            end
            req_valid[i] = v;
            req_data[8*i +: 8] = (pos[i] < blen[i]) ? bufm[i][pos[i]] : 8'h00;
            req_last[i] = (pos[i] == blen[i] - 1);
        end
    endtask

    task automatic load(input int id, input string s);
        for (int k = 0; k < s.len(); k++) bufm[id][k] = s[k];
        blen[id] = s.len();
        pos[id] = 0;
        drive();
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) acc[i] = req_valid[i] & req_ready[i];
        if (chk_clr) begin
            clr_cnt++;
            if (first_clr < 0) first_clr = cyc;
        end
        if (chk_en) begin
            if (en_cnt < 64) en_chars[en_cnt] = chk_in;
            en_cnt++;
            if (first_en < 0) first_en = cyc;
        end else if (chk_in != 8'h00) begin
            chkin_bad++;
        end
        for (int i = 0; i < N; i++) if (acc[i] && req_last[i]) last_acc = cyc;
        if (done_valid && !dv_prev) dv_rise = cyc;
        if (done_valid && done_ready) begin
            rec_t r;
            r.id = int'(done_id); r.len = int'(done_len);
            r.res = done_result; r.ovf = done_ovf; r.vcyc = dv_rise;
            recs.push_back(r);
            hs_cyc = cyc;
        end
        dv_prev = done_valid;
        if (in_gap) begin
            gap_seen++;
            if (chk_en) gap_en++;
            if (done_len != 16'd4) gap_len_bad++;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) if (acc[i]) pos[i]++;
        drive();
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (recs.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (recs.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d records, expected %0d", tag, recs.size(), n);
        end
    endtask

    task automatic clear_mon();
        clr_cnt = 0; en_cnt = 0; first_clr = -1; first_en = -1; last_acc = -1;
        recs.delete();
    endtask

    function automatic longint outs_a();
        return {busy, done_valid, chk_clr, chk_en, chk_in, req_ready,
                done_id, done_result, done_len, done_ovf};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        byte  bch [8];
        int   bpos, ben, bdrain, bbad, bclr, stall_bad;
        bit   bgot;
        rec_t bref;
        rec_t held;

        vecs[0] = mk(0, "begin end", 1'b1);
        vecs[1] = mk(1, "bxd", 1'b1);
        vecs[2] = mk(3, "bbd", 1'b0);
        vecs[3] = mk(2, "xyz", 1'b1);
        vecs[4] = mk(1, "d", 1'b0);

        for (int i = 0; i < N; i++) begin
            blen[i] = 0; pos[i] = 0; gap_at[i] = -1; gap_left[i] = 0;
        end
        chkin_bad = 0; gap_seen = 0; gap_en = 0; gap_len_bad = 0;
        dv_prev = 1'b0; dv_rise = -1; hs_cyc = -1;
        done_ready = 1'b1;
        b_req_valid = '0; b_req_last = '0; b_req_data = '0;
        b_done_ready = 1'b1; b_chk_result = 1'b1;
        clear_mon();
        reset = 1'b0;
        drive();

        // Reset state
        tick(); tick();
        chk("reset_outputs", outs_a(), 0);
        chk("reset_busy_ovfdut", {b_busy, b_done_valid, b_req_ready}, 0);
        reset = 1'b1;
        tick();
        chk("idle_after_release", outs_a(), 0);

        // Table of single strings
        for (int v = 0; v < 5; v++) begin
            int bad;
            clear_mon();
            load(vecs[v].id, vecs[v].s);
            wait_done(1, 80, "vec");
            if (recs.size() > 0) begin
                chk($sformatf("vec%0d_id", v), recs[0].id, vecs[v].id);
                chk($sformatf("vec%0d_len", v), recs[0].len, vecs[v].s.len());
                chk($sformatf("vec%0d_result", v), recs[0].res, vecs[v].res);
                chk($sformatf("vec%0d_ovf", v), recs[0].ovf, 0);
                chk($sformatf("vec%0d_latency", v), recs[0].vcyc - last_acc, 2);
            end
            chk($sformatf("vec%0d_clr_pulses", v), clr_cnt, 1);
            chk($sformatf("vec%0d_en_cycles", v), en_cnt, vecs[v].s.len());
            bad = 0;
            for (int k = 0; k < vecs[v].s.len(); k++)
                if (k >= en_cnt || en_chars[k] != vecs[v].s[k]) bad++;
            chk($sformatf("vec%0d_chk_in_stream", v), bad, 0);
        end

        // Round-robin order from reset, then wrap-around
        reset = 1'b0; tick(); tick(); reset = 1'b1;
        clear_mon();
        load(0, "bcd"); load(1, "bbb"); load(2, "ddd");
        wait_done(3, 120, "rr1");
        if (recs.size() == 3) begin
            chk("rr1_first", recs[0].id, 0);
            chk("rr1_second", recs[1].id, 1);
            chk("rr1_third", recs[2].id, 2);
            chk("rr1_results", {recs[0].res, recs[1].res, recs[2].res}, 3'b100);
            chk("rr1_len", recs[1].len, 3);
        end
        clear_mon();
        load(0, "xxx"); load(1, "ddb"); load(3, "bdb");
        wait_done(3, 120, "rr2");
        if (recs.size() == 3) begin
            chk("rr2_first", recs[0].id, 3);
            chk("rr2_second", recs[1].id, 0);
            chk("rr2_third", recs[2].id, 1);
            chk("rr2_results", {recs[0].res, recs[1].res, recs[2].res}, 3'b010);
        end

        // Back-pressure on the done channel with another requester waiting
        clear_mon();
        done_ready = 1'b0;
        load(1, "bbd"); load(2, "xyz");
        for (int k = 0; k < 60 && !done_valid; k++) tick();
        chk("stall_done_valid", done_valid, 1);
        held.id = int'(done_id); held.len = int'(done_len);
        held.res = done_result; held.ovf = done_ovf; held.vcyc = 0;
        chk("stall_first_id", held.id, 2);
        stall_bad = 0;
        clr_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (!done_valid || int'(done_id) != held.id || int'(done_len) != held.len ||
                done_result != held.res || done_ovf != held.ovf || req_ready != '0)
                stall_bad++;
        end
        chk("stall_fields_stable", stall_bad, 0);
        chk("stall_no_clr", clr_cnt, 0);
        done_ready = 1'b1;
        first_clr = -1;
        wait_done(2, 80, "stall");
        if (recs.size() == 2) begin
            chk("stall_rec0_res", recs[0].res, 1);
            chk("stall_rec1_id", recs[1].id, 1);
            chk("stall_rec1_res", recs[1].res, 0);
        end
        chk("stall_regrant_gap", first_clr - recs[0].vcyc - 5, 2);

        // Owner stalls mid-string
        clear_mon();
        gap_at[0] = 4; gap_left[0] = 3;
        load(0, "begin end");
        wait_done(1, 80, "gap");
        chk("gap_cycles", gap_seen, 3);
        chk("gap_no_en", gap_en, 0);
        chk("gap_len_held", gap_len_bad, 0);
        chk("gap_en_total", en_cnt, 9);
        if (recs.size() > 0) begin
            chk("gap_len", recs[0].len, 9);
            chk("gap_result", recs[0].res, 1);
        end
        gap_at[0] = -1;

        // Overflow on the MAX_LEN=4 instance
        bch[0] = "a"; bch[1] = "b"; bch[2] = "c"; bch[3] = "d";
        bch[4] = "e"; bch[5] = "f"; bch[6] = "g"; bch[7] = "h";
        bpos = 0; ben = 0; bdrain = 0; bbad = 0; bclr = 0; bgot = 1'b0;
        bref.id = -1; bref.len = -1; bref.res = 1'b1; bref.ovf = 1'b0; bref.vcyc = 0;
        for (int k = 0; k < 40 && !bgot; k++) begin
            b_req_valid = (bpos < 7) ? 4'b0100 : 4'b0000;
            b_req_last  = (bpos == 6) ? 4'b0100 : 4'b0000;
            b_req_data  = {8'h00, bch[bpos], 16'h0000};
            @(negedge clk);
            if (b_chk_clr) bclr++;
            if (b_chk_en) begin
                if (ben < 8 && b_chk_in != bch[ben]) bbad++;
                ben++;
            end
            if (b_req_valid[2] && b_req_ready[2]) begin
                if (!b_chk_en) bdrain++;
                bpos++;
            end
            if (b_done_valid) begin
                bgot = 1'b1;
                bref.id = int'(b_done_id); bref.len = int'(b_done_len);
                bref.res = b_done_result; bref.ovf = b_done_ovf;
            end
            @(posedge clk);
            #1;
        end
        b_req_valid = '0; b_req_last = '0;
        chk("ovf_done_seen", bgot, 1);
        chk("ovf_clr", bclr, 1);
        chk("ovf_en_cycles", ben, 4);
        chk("ovf_drained", bdrain, 3);
        chk("ovf_chk_in", bbad, 0);
        chk("ovf_id", bref.id, 2);
        chk("ovf_len", bref.len, 4);
        chk("ovf_flag", bref.ovf, 1);
        chk("ovf_result", bref.res, 0);

        // Reset in the middle of a string
        clear_mon();
        load(2, "bbbbbb");
        for (int k = 0; k < 40 && en_cnt < 2; k++) tick();
        chk("rst_pre_en", en_cnt, 2);
        reset = 1'b0;
        #1;
        chk("rst_async_outputs", outs_a(), 0);
        load(0, "bcd");
        tick(); tick();
        chk("rst_held_outputs", outs_a(), 0);
        clear_mon();
        reset = 1'b1;
        wait_done(2, 100, "rst");
        if (recs.size() == 2) begin
            chk("rst_first_owner", recs[0].id, 0);
            chk("rst_first_len", recs[0].len, 3);
            chk("rst_second_owner", recs[1].id, 2);
            chk("rst_second_len", recs[1].len, 4);
        end
        chk("rst_clr_before_en", first_en - first_clr, 1);

        chk("chk_in_zero_when_idle", chkin_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_check_scheduler.md
Name: block_check_scheduler

Overview:
- Round-robin scheduler that shares one keyword block-checker (begin/end nesting checker on an 8-bit character stream) among N_REQ character sources.
- Grants the checker to one requester for a whole string (first char through `last`), clears the checker before each string, and streams the characters into it.
- After the string completes, captures the checker's `result` and returns it, tagged with requester id and length, on a done channel.
- Sits between the text-source front ends and the single checker instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id; must equal clog2(N_REQ).
- MAX_LEN, 1024, maximum characters per string before forced abort (≥2).
- LEN_W, 16, width of length counter; 2^LEN_W > MAX_LEN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  N_REQ  per-requester character valid.
- req_data  in  8*N_REQ  per-requester character; requester i uses bits [8i+7:8i].
- req_last  in  N_REQ  marks final character of a string.
- req_ready  out  N_REQ  per-requester accept.
- chk_clr  out  1  one-cycle clear pulse to the checker.
- chk_en  out  1  checker advances on this cycle.
- chk_in  out  8  character to the checker.
- chk_result  in  1  checker verdict; valid one cycle after the last chk_en.
- done_valid  out  1  completion record valid.
- done_ready  in  1  consumer accepts the record.
- done_id  out  ID_W  owning requester.
- done_result  out  1  captured verdict; forced 0 on overflow.
- done_len  out  LEN_W  characters delivered to the checker.
- done_ovf  out  1  string exceeded MAX_LEN.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer = N_REQ-1, so requester 0 has top priority first.
- States: IDLE, CLEAR, STREAM, DRAIN, SETTLE, REPORT.
- IDLE:
  - Pick the first asserted req_valid searching from (ptr+1) mod N_REQ upward with wrap.
  - Latch it as owner; set ptr=owner; go to CLEAR. No req_ready in IDLE.
- CLEAR:
  - chk_clr=1 for exactly one cycle.
  - Clear len and ovf; go to STREAM.
- STREAM:
  - req_ready[owner]=1, all others 0.
  - A char is accepted when req_valid[owner]&req_ready[owner]. On acceptance: chk_en=1, chk_in=owner data combinationally, len+=1.
  - When chk_en=0, chk_in holds 0.
  - If the accepted char has last=1 → SETTLE.
  - Else if len+1 == MAX_LEN → set ovf and go to DRAIN. This char is still delivered.
- DRAIN:
  - req_ready[owner]=1, chk_en=0; characters are discarded.
  - Accepted char with last=1 → SETTLE.
- SETTLE:
  - One cycle; capture done_result = chk_result & ~ovf; go to REPORT.
  - Fixed latency: last char accepted at cycle t → done_valid asserted at t+2.
- REPORT:
  - done_valid=1; done_id/result/len/ovf stable until done_valid&done_ready, then → IDLE.
  - Next grant can occur at the earliest one cycle after the handshake.
- Other rules:
  - Zero-length strings are impossible: the first char starts a string.
  - A requester dropping req_valid mid-string simply stalls STREAM; there is no timeout.
  - Non-owner req_valid is ignored while busy and never lost, because requesters hold valid.
  - reset asserted mid-operation returns immediately to IDLE with all outputs 0. No done record is emitted for the interrupted string, and ptr resets to N_REQ-1.
  - len is clamped at MAX_LEN; the counter never wraps.

Decomposition:
- Shared package block_check_pkg:
  - state enum (IDLE, CLEAR, STREAM, DRAIN, SETTLE, REPORT).
  - localparam for the 3-bit state width.
  - Default character code constants reused by the checker.
- One sub-module, rr_arbiter:
  - Purely combinational.
  - Inputs: N_REQ-bit request vector, ptr.
  - Outputs: grant_valid, grant_id.
- Top holds the FSM, owner/len/ovf registers, the data mux, and the done register.

Test Plan:
- Single requester 0 sends "begin end" (9 chars, last on 'd'); model checker returns 1 → one chk_clr pulse, 9 chk_en cycles, done_id=0, done_len=9, done_result=1, done_ovf=0, done_valid 2 cycles after the 'd' handshake.
- Requesters 0,1,2 all valid in IDLE after reset, each sending a 3-char string → grant order 0,1,2; then requester 0 again with 1 and 3 re-requesting → order 3 then 0 (wrap-around).
- MAX_LEN=4, requester 2 sends 7 chars with last on the 7th → exactly 4 chk_en cycles, 3 chars drained, done_len=4, done_ovf=1, done_result=0.
- done_ready held 0 for 5 cycles in REPORT with other requests pending → done fields stable, no req_ready asserted, no new chk_clr until the handshake.
- Owner deasserts req_valid for 3 cycles mid-string → no chk_en during the gap, len unchanged, string completes normally afterwards.
- reset driven to 0 during STREAM after 2 chars → all outputs 0 the same cycle; after release, requester 0 granted first and chk_clr pulses before its first char.
